// File: rtl/cd_rs_syndrome.sv
// Reed-Solomon syndrome generator: Horner-evaluates N_SYN syndromes over GF(256),
// one symbol per cycle, and hands each codeword's syndrome vector out under valid/ready.
module cd_rs_syndrome #(
  parameter int N_SYM = 32,
  parameter int N_SYN = 4,
  parameter int ROOT0 = 0,
  parameter logic [8:0] POLY = 9'h11D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*N_SYN-1:0]   out_syn,
  output logic                 out_zero,
  output logic [7:0]           sym_cnt
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; out_valid/out_syn hold steady until that transfer happens.

  localparam logic [7:0] LAST = 8'(N_SYM - 1);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ POLY[7:0]) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_pow(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < e; i++) r = gf_mul(r, 8'h02);
    return r;
  endfunction

  logic [8*N_SYN-1:0] acc;
  logic [8*N_SYN-1:0] acc_nxt;
  logic               last;
  logic               accept;

  // Each lane multiplies by its own constant root, so the multiplier folds to XORs.
  for (genvar j = 0; j < N_SYN; j++) begin : g_lane
    localparam logic [7:0] ROOT = gf_pow(ROOT0 + j);
    assign acc_nxt[8*j +: 8] = gf_mul(acc[8*j +: 8], ROOT) ^ in_data;
  end

  assign last     = (sym_cnt == LAST);
  assign in_ready = !(last && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      sym_cnt   <= 8'd0;
      out_syn   <= '0;
      out_valid <= 1'b0;
      out_zero  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (flush) begin
        acc     <= '0;
        sym_cnt <= 8'd0;
      end else if (accept) begin
        if (last) begin
          // A fresh load overrides the handshake clear above.
          out_syn   <= acc_nxt;
          out_zero  <= ~|acc_nxt;
          out_valid <= 1'b1;
          acc       <= '0;
          sym_cnt   <= 8'd0;
        end else begin
          acc     <= acc_nxt;
          sym_cnt <= sym_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cd_rs_syndrome.sv
// Self-checking bench for cd_rs_syndrome (C1 defaults): table vectors, random
// codewords against a log/antilog power-sum model, and handshake/flush/reset corners.
module tb_cd_rs_syndrome;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_syn;
  logic        out_zero;
  logic [7:0]  sym_cnt;

  cd_rs_syndrome dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_syn(out_syn),
    .out_zero(out_zero), .sym_cnt(sym_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Queue entry layout: {zero, byte mask, syndromes}.
  logic [64:0] exp_q[$];

  logic [7:0] exp_t[255];
  int         log_t[256];
  logic [7:0] cw[32];

  typedef struct {
    int          pos_a;
    logic [7:0]  val_a;
    int          pos_b;
    logic [7:0]  val_b;
    logic [31:0] exp_syn;
    logic [31:0] mask;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  // S_j = sum_i r[i] * alpha^(j*i); cw[k] carries r[31-k].
  function automatic logic [64:0] ref_exp();
    logic [31:0] s;
    s = '0;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 32; i++)
        s[8*j +: 8] = s[8*j +: 8] ^ gm(cw[31-i], exp_t[(j*i) % 255]);
    return {(s == 32'h0), 32'hFFFF_FFFF, s};
  endfunction

  always @(negedge clk) begin
    logic [64:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_syn", 64'(out_syn & e[63:32]), 64'(e[31:0] & e[63:32]));
        check("out_zero", 64'(out_zero), 64'(e[64]));
      end
    end
  end

  task automatic send_sym(input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check("in_ready_timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic send_cw(input bit push);
    for (int k = 0; k < 32; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      if (k == 31 && push) exp_q.push_back(ref_exp());
      send_sym(cw[k]);
    end
    @(negedge clk);
    check("cnt_wrap", 64'(sym_cnt), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cw();
    for (int k = 0; k < 32; k++) cw[k] = 8'($urandom_range(0, 255));
  endtask

  task automatic sparse_cw(input int pos, input logic [7:0] v);
    for (int k = 0; k < 32; k++) cw[k] = 8'h00;
    if (pos >= 0) cw[31-pos] = v;
  endtask

  initial begin
    logic [64:0] exp_a;
    logic [64:0] exp_b;
    logic [7:0]  x;
    int          n;

    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end

    vecs[0] = '{-1, 8'h00, -1, 8'h00, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
    vecs[1] = '{31, 8'h5A, 30, 8'hA5, 32'h0000_00FF, 32'h0000_00FF, 1'b0};
    vecs[2] = '{ 1, 8'h01, -1, 8'h00, 32'h0804_0201, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{ 0, 8'h37, -1, 8'h00, 32'h3737_3737, 32'hFFFF_FFFF, 1'b0};
    vecs[4] = '{31, 8'h01, -1, 8'h00, 32'h0000_0001, 32'h0000_00FF, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_syn", 64'(out_syn), 64'd0);
    check("rst_out_zero", 64'(out_zero), 64'd0);
    check("rst_sym_cnt", 64'(sym_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table vectors.
    for (int v = 0; v < 5; v++) begin
      sparse_cw(vecs[v].pos_a, vecs[v].val_a);
      if (vecs[v].pos_b >= 0) cw[31-vecs[v].pos_b] = vecs[v].val_b;
      for (int k = 0; k < 31; k++) send_sym(cw[k]);
      exp_q.push_back({vecs[v].exp_zero, vecs[v].mask, vecs[v].exp_syn});
      send_sym(cw[31]);
      @(negedge clk);
      check("tbl_cnt_wrap", 64'(sym_cnt), 64'd0);
      @(posedge clk);
      #1;
    end

    // Random codewords with random input gaps.
    for (int r = 0; r < 4; r++) begin
      rand_cw();
      send_cw(1'b1);
    end

    // Backpressure across two back-to-back codewords.
    out_ready = 1'b0;
    rand_cw();
    exp_a = ref_exp();
    send_cw(1'b1);
    rand_cw();
    exp_b = ref_exp();
    for (int k = 0; k < 31; k++) send_sym(cw[k]);
    in_valid = 1'b1;
    in_data  = cw[31];
    exp_q.push_back(exp_b);
    @(negedge clk);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    check("stall_out_syn", 64'(out_syn), 64'(exp_a[31:0]));
    @(posedge clk);
    #1;
    check("stall_hold_syn", 64'(out_syn), 64'(exp_a[31:0]));
    check("stall_hold_cnt", 64'(sym_cnt), 64'd31);
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("reload_out_valid", 64'(out_valid), 64'd1);
    check("reload_out_syn", 64'(out_syn), 64'(exp_b[31:0]));
    check("reload_sym_cnt", 64'(sym_cnt), 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Flush after 10 symbols, then a codeword with only r[0]=0x37.
    for (int k = 0; k < 10; k++) send_sym(8'($urandom_range(1, 255)));
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_sym_cnt", 64'(sym_cnt), 64'd0);
    @(posedge clk);
    #1;
    sparse_cw(0, 8'h37);
    send_cw(1'b1);

    // Flush coincident with an accepted symbol drops it.
    for (int k = 0; k < 5; k++) send_sym(8'($urandom_range(1, 255)));
    in_valid = 1'b1;
    in_data  = 8'hAB;
    flush    = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_drop_cnt", 64'(sym_cnt), 64'd0);
    @(posedge clk);
    #1;
    sparse_cw(0, 8'h37);
    send_cw(1'b1);

    // Reset mid-codeword with an output pending.
    out_ready = 1'b0;
    rand_cw();
    send_cw(1'b0);
    for (int k = 0; k < 17; k++) send_sym(8'($urandom_range(0, 255)));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_syn", 64'(out_syn), 64'd0);
    check("mid_rst_out_zero", 64'(out_zero), 64'd0);
    check("mid_rst_sym_cnt", 64'(sym_cnt), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    rand_cw();
    send_cw(1'b1);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cd_rs_syndrome.md
Name: cd_rs_syndrome

Overview:
- Parametrised Reed-Solomon syndrome generator for the CD CIRC decoder path.
- Builds on the registered GF(256) multiply stage: it streams one 8-bit symbol per cycle and accumulates N_SYN syndromes in parallel by Horner evaluation.
- One codeword of N_SYM symbols produces one registered syndrome vector, held under a valid/ready handshake.
- Sits between the symbol deinterleave buffer and the C1/C2 error locator; defaults cover C1 (32,28). C2 uses N_SYM=28.

Parameters:
- N_SYM, 32, symbols per codeword (2..255).
- N_SYN, 4, number of syndromes (1..16).
- ROOT0, 0, exponent of the first generator root; syndrome j uses root alpha^(ROOT0+j).
- POLY, 9'h11D, GF(256) field polynomial x^8+x^4+x^3+x^2+1; alpha = 0x02.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- flush  input  1  abandons the codeword in progress (sync, one-cycle pulse).
- in_valid  input  1  in_data holds a symbol.
- in_ready  output  1  block accepts a symbol this cycle.
- in_data  input  8  received symbol; first symbol is the highest-degree coefficient r[N_SYM-1].
- out_valid  output  1  syndrome vector is available.
- out_ready  input  1  consumer takes the syndrome vector.
- out_syn  output  8*N_SYN  syndrome j in bits [8j+7:8j].
- out_zero  output  1  all syndromes are zero (codeword error-free); qualified by out_valid.
- sym_cnt  output  8  symbols accepted in the current codeword (debug).

Behaviour:
- Reset (rst_n=0 at clk edge): accumulators, sym_cnt, out_syn, out_valid and out_zero are all cleared to 0. in_ready then reflects the reset state and reads 1.
- Accept: a symbol is accepted when in_valid && in_ready.
- Per accepted symbol: acc[j] <= gfmul(acc[j], alpha^(ROOT0+j)) ^ in_data for every j, then sym_cnt++.
  - alpha^(ROOT0+j) are elaboration-time constants.
  - gfmul is the full GF(256) multiply reduced by POLY; no carries and no widths beyond 8 bits.
- Last symbol (sym_cnt==N_SYM-1 when accepted):
  - The next-state accumulator values go straight into out_syn, and out_valid is set on the same edge.
  - The accumulators and sym_cnt return to 0, so the next codeword starts back-to-back with no bubble.
  - Latency: last symbol at edge t gives out_valid=1 after edge t; the symbol is included in out_syn.
- out_zero is registered together with out_syn and equals the NOR of all loaded syndromes.
- Output handshake:
  - out_valid stays high and out_syn stays stable until out_valid && out_ready, which clears out_valid on that edge.
  - A new load on the same edge as a handshake takes priority: out_valid stays 1 and the new data is loaded.
- Backpressure: in_ready = !(sym_cnt==N_SYM-1 && out_valid && !out_ready).
  - Only the final symbol can stall; accumulation of earlier symbols continues while a result is pending.
- flush:
  - Clears the accumulators and sym_cnt; out_syn, out_valid and out_zero are untouched.
  - flush has priority over a symbol accepted in the same cycle; that symbol is dropped.
  - in_ready is not gated by flush.
- Reset has priority over flush and all other inputs, including reset in the middle of a codeword or while an output is pending.
- in_data is ignored when the symbol is not accepted.
- sym_cnt wraps only through the last-symbol rule and never reaches N_SYM.

Test Plan:
- All-zero codeword, 32 symbols of 0x00 with in_valid held 1 -> one out_valid pulse after the 32nd edge; out_syn=0, out_zero=1; sym_cnt returns to 0.
- Symbols r[31]=0x5A, r[30]=0xA5, rest 0x00 (ROOT0=0) -> S0=0xFF; out_zero=0.
- Only r[1]=0x01 (second-to-last symbol) -> S0=0x01, S1=0x02, S2=0x04, S3=0x08.
- out_ready held 0 over two back-to-back codewords -> in_ready drops while symbol 31 of the second codeword is presented; first out_syn stays stable; raising out_ready for one cycle loads the second result with out_valid staying 1.
- flush after 10 symbols, then a full codeword with only r[0]=0x37 (last symbol) -> all four syndromes 0x37; the flushed symbols have no effect. Repeat with flush coincident with an accepted symbol -> that symbol is dropped.
- rst_n=0 for one cycle at symbol 17 while out_valid=1 -> all outputs 0 and in_ready=1 on the next cycle; the following 32-symbol codeword produces correct syndromes.
